// File: rtl/processor_pkg.sv
// -----------------------------------------------------------------------------
// processor_pkg
// Shared definitions for the boot-time memory loader:
//   - memory geometry (RAM2Kx32): ADDRESS_WIDTH, DATA_WIDTH, MEM_DEPTH
//   - active-low strobe levels STROBE_ON / STROBE_OFF
//   - loader_state_t, the loader session state enum
// -----------------------------------------------------------------------------
package processor_pkg;

    localparam int ADDRESS_WIDTH = 11;
    localparam int DATA_WIDTH    = 32;
    localparam int MEM_DEPTH     = 2048;

    // Memory strobes (cen/wen/oen) are active-low
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_IM = 3'd1,
        LOAD_DM = 3'd2,
        DRAIN   = 3'd3,
        RELEASE = 3'd4,
        RUN     = 3'd5
    } loader_state_t;

endpackage

// File: rtl/load_port_driver.sv
// -----------------------------------------------------------------------------
// load_port_driver
// Registered write-port driver for one memory. An accept pulse in cycle N
// produces a single write (cen=0, wen=0, oen=1) in cycle N+1 at the given
// index with the given data; strobes are inactive in every other cycle.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   accept          word accepted for this memory this cycle
//   index, data     word address and word value to write
//   cen, wen, oen   active-low memory strobes (registered)
//   addr, datain    memory address / write data (registered, held between writes)
// -----------------------------------------------------------------------------
module load_port_driver
    import processor_pkg::*;
#(
    parameter int AW = ADDRESS_WIDTH,
    parameter int DW = DATA_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          accept,
    input  logic [AW-1:0] index,
    input  logic [DW-1:0] data,
    output logic          cen,
    output logic          wen,
    output logic          oen,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] datain
);

    logic          cen_q, cen_d;
    logic          wen_q, wen_d;
    logic          oen_q, oen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] datain_q, datain_d;

    // Next write-port values: one write cycle per accepted word
    always_comb begin
        oen_d = STROBE_OFF;
        if (accept) begin
            cen_d    = STROBE_ON;
            wen_d    = STROBE_ON;
            addr_d   = index;
            datain_d = data;
        end else begin
            cen_d    = STROBE_OFF;
            wen_d    = STROBE_OFF;
            addr_d   = addr_q;
            datain_d = datain_q;
        end
    end

    // Write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cen_q    <= STROBE_OFF;
            wen_q    <= STROBE_OFF;
            oen_q    <= STROBE_OFF;
            addr_q   <= {AW{1'b0}};
            datain_q <= {DW{1'b0}};
        end else begin
            cen_q    <= cen_d;
            wen_q    <= wen_d;
            oen_q    <= oen_d;
            addr_q   <= addr_d;
            datain_q <= datain_d;
        end
    end

    assign cen    = cen_q;
    assign wen    = wen_q;
    assign oen    = oen_q;
    assign addr   = addr_q;
    assign datain = datain_q;

endmodule

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader
// Boot-time initiator for the processor memory load port. After a start pulse
// it takes im_words stream words into instruction memory, then dm_words into
// data memory (each clamped to MEM_DEPTH), holding the core in reset, then
// drains the last write, drops loading, and releases core_rst_n.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle session request (honoured in IDLE only)
//   im_words, dm_words       word counts, ADDRESS_WIDTH+1 bits
//   in_valid/in_data/in_ready  stream handshake (in_ready registered)
//   loading                  processor loading select
//   im_*_load, dm_*_load     active-low strobes, address and data per memory
//   core_rst_n               processor reset, low until release
//   busy, done               session in progress / one-cycle release pulse
//   checksum                 only with LOADER_CHECKSUM_EN: mod-2^DATA_WIDTH sum
//                            of the words accepted this session
// -----------------------------------------------------------------------------
module mem_loader #(
    parameter int ADDRESS_WIDTH = processor_pkg::ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = processor_pkg::DATA_WIDTH,
    parameter int MEM_DEPTH     = processor_pkg::MEM_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH:0]   im_words,
    input  logic [ADDRESS_WIDTH:0]   dm_words,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     loading,
    output logic                     im_cen_load,
    output logic                     im_wen_load,
    output logic                     im_oen_load,
    output logic [ADDRESS_WIDTH-1:0] im_addr_load,
    output logic [DATA_WIDTH-1:0]    im_datain_load,
    output logic                     dm_cen_load,
    output logic                     dm_wen_load,
    output logic                     dm_oen_load,
    output logic [ADDRESS_WIDTH-1:0] dm_addr_load,
    output logic [DATA_WIDTH-1:0]    dm_datain_load,
    output logic                     core_rst_n,
    output logic                     busy,
    output logic                     done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]    checksum
`endif
);

    import processor_pkg::*;

    localparam int              CW      = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0]   DEPTH_W = CW'(MEM_DEPTH);
    localparam logic [CW-1:0]   ZERO_W  = {CW{1'b0}};
    localparam logic [CW-1:0]   ONE_W   = {{ADDRESS_WIDTH{1'b0}}, 1'b1};

    loader_state_t state_q, state_d;
    logic [CW-1:0] im_words_q, im_words_d, dm_words_q, dm_words_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] im_clamp_s, dm_clamp_s, idx_inc_s, target_s;
    logic          session_start_s, accept_s, last_s, im_accept_s, dm_accept_s;
    logic          in_ready_q, in_ready_d, loading_q, loading_d;
    logic          busy_q, busy_d, done_q, done_d, core_rst_n_q, core_rst_n_d;

    assign session_start_s = (state_q == IDLE) && start;
    assign accept_s        = in_valid && in_ready_q;
    assign im_accept_s     = accept_s && (state_q == LOAD_IM);
    assign dm_accept_s     = accept_s && (state_q == LOAD_DM);
    assign idx_inc_s       = idx_q + ONE_W;
    assign last_s          = (idx_inc_s == target_s);

    // Clamp requested counts to the memory depth; pick the active phase's count
    always_comb begin
        if (im_words > DEPTH_W) im_clamp_s = DEPTH_W;
        else                    im_clamp_s = im_words;
        if (dm_words > DEPTH_W) dm_clamp_s = DEPTH_W;
        else                    dm_clamp_s = dm_words;
        if (state_q == LOAD_IM) target_s = im_words_q;
        else                    target_s = dm_words_q;
    end

    // Session counts are latched at start; word index restarts per memory
    always_comb begin
        if (session_start_s) begin
            im_words_d = im_clamp_s;
            dm_words_d = dm_clamp_s;
        end else begin
            im_words_d = im_words_q;
            dm_words_d = dm_words_q;
        end
        if (accept_s) begin
            if (last_s) idx_d = ZERO_W;
            else        idx_d = idx_inc_s;
        end else begin
            idx_d = idx_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!start)                 state_d = IDLE;
                else if (im_clamp_s != ZERO_W) state_d = LOAD_IM;
                else if (dm_clamp_s != ZERO_W) state_d = LOAD_DM;
                else                        state_d = DRAIN;
            end
            LOAD_IM: begin
                if (accept_s && last_s) begin
                    if (dm_words_q != ZERO_W) state_d = LOAD_DM;
                    else                      state_d = DRAIN;
                end else begin
                    state_d = LOAD_IM;
                end
            end
            LOAD_DM: begin
                if (accept_s && last_s) state_d = DRAIN;
                else                    state_d = LOAD_DM;
            end
            DRAIN:   state_d = RELEASE;
            RELEASE: state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered control outputs. in_ready is cleared in
    // the cycle the session's final word is accepted, so no extra word is taken.
    always_comb begin
        in_ready_d   = 1'b0;
        loading_d    = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        core_rst_n_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    loading_d  = 1'b1;
                    busy_d     = 1'b1;
                    in_ready_d = (im_clamp_s != ZERO_W) || (dm_clamp_s != ZERO_W);
                end else begin
                    loading_d  = 1'b0;
                    busy_d     = 1'b0;
                    in_ready_d = 1'b0;
                end
            end
            LOAD_IM: begin
                loading_d  = 1'b1;
                busy_d     = 1'b1;
                in_ready_d = !(accept_s && last_s && (dm_words_q == ZERO_W));
            end
            LOAD_DM: begin
                loading_d  = 1'b1;
                busy_d     = 1'b1;
                in_ready_d = !(accept_s && last_s);
            end
            DRAIN: begin
                busy_d = 1'b1;
            end
            RELEASE: begin
                core_rst_n_d = 1'b1;
                done_d       = 1'b1;
            end
            RUN: begin
                core_rst_n_d = 1'b1;
            end
            default: begin
                loading_d = 1'b0;
            end
        endcase
    end

    // State, counters and control-output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            im_words_q   <= ZERO_W;
            dm_words_q   <= ZERO_W;
            idx_q        <= ZERO_W;
            in_ready_q   <= 1'b0;
            loading_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            im_words_q   <= im_words_d;
            dm_words_q   <= dm_words_d;
            idx_q        <= idx_d;
            in_ready_q   <= in_ready_d;
            loading_q    <= loading_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign loading    = loading_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign core_rst_n = core_rst_n_q;

    load_port_driver #(.AW(ADDRESS_WIDTH), .DW(DATA_WIDTH)) u_im_port (
        .clk    (clk),
        .rst    (rst),
        .accept (im_accept_s),
        .index  (idx_q[ADDRESS_WIDTH-1:0]),
        .data   (in_data),
        .cen    (im_cen_load),
        .wen    (im_wen_load),
        .oen    (im_oen_load),
        .addr   (im_addr_load),
        .datain (im_datain_load)
    );

    load_port_driver #(.AW(ADDRESS_WIDTH), .DW(DATA_WIDTH)) u_dm_port (
        .clk    (clk),
        .rst    (rst),
        .accept (dm_accept_s),
        .index  (idx_q[ADDRESS_WIDTH-1:0]),
        .data   (in_data),
        .cen    (dm_cen_load),
        .wen    (dm_wen_load),
        .oen    (dm_oen_load),
        .addr   (dm_addr_load),
        .datain (dm_datain_load)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

    // Running wrap-around sum of accepted words, restarted with each session
    always_comb begin
        if (session_start_s)  checksum_d = {DATA_WIDTH{1'b0}};
        else if (accept_s)    checksum_d = checksum_q + in_data;
        else                  checksum_d = checksum_q;
    end

    // Checksum register
    always_ff @(posedge clk) begin
        if (rst) checksum_q <= {DATA_WIDTH{1'b0}};
        else     checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader
// Directed bench for mem_loader. A scoreboard built from the session rules
// (first min(im,2048) stream words go to IM addresses 0.., the next words to DM
// addresses 0..) is compared against every write strobe seen on the ports;
// timing rules (loading falls 2 cycles after the last accept, release one cycle
// later, single done pulse) and hand-computed literals pin the model.
// -----------------------------------------------------------------------------
module tb_mem_loader;
    import processor_pkg::*;

    localparam int AW = ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int CW = AW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] im_words = '0;
    logic [CW-1:0] dm_words = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, loading, core_rst_n, busy, done;
    logic          im_cen_load, im_wen_load, im_oen_load;
    logic          dm_cen_load, dm_wen_load, dm_oen_load;
    logic [AW-1:0] im_addr_load, dm_addr_load;
    logic [DW-1:0] im_datain_load, dm_datain_load;
`ifdef LOADER_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    mem_loader dut (
        .clk(clk), .rst(rst), .start(start), .im_words(im_words), .dm_words(dm_words),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .loading(loading),
        .im_cen_load(im_cen_load), .im_wen_load(im_wen_load), .im_oen_load(im_oen_load),
        .im_addr_load(im_addr_load), .im_datain_load(im_datain_load),
        .dm_cen_load(dm_cen_load), .dm_wen_load(dm_wen_load), .dm_oen_load(dm_oen_load),
        .dm_addr_load(dm_addr_load), .dm_datain_load(dm_datain_load),
        .core_rst_n(core_rst_n), .busy(busy), .done(done)
`ifdef LOADER_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected writes and the stream for the current session
    logic [DW-1:0] stim[$];
    bit            vpat[$];
    bit            exp_dm[$];
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic [DW-1:0] im_shadow [0:2047];
    logic [DW-1:0] dm_shadow [0:2047];

    // Session trackers written by the monitor
    int   done_cnt, fall_cyc, rise_cyc, done_cyc, acc_cnt, last_acc, nwr;
    bit   ready_seen;
    logic rdy_after;
    logic [AW-1:0] last_im_addr;
    logic loading_prev = 1'b0;
    logic core_prev = 1'b0;

    task automatic clear_trk();
        done_cnt = 0; fall_cyc = -1; rise_cyc = -1; done_cyc = -1;
        acc_cnt = 0; last_acc = -1; nwr = 0; ready_seen = 0; rdy_after = 1'b1;
        exp_dm.delete(); exp_addr.delete(); exp_data.delete();
    endtask

    // Expected writes from the session rules
    task automatic push_expect(input int im, input int dm);
        int imc = (im > MEM_DEPTH) ? MEM_DEPTH : im;
        int dmc = (dm > MEM_DEPTH) ? MEM_DEPTH : dm;
        for (int i = 0; i < imc && i < stim.size(); i++) begin
            exp_dm.push_back(1'b0); exp_addr.push_back(AW'(i)); exp_data.push_back(stim[i]);
        end
        for (int j = 0; j < dmc && imc + j < stim.size(); j++) begin
            exp_dm.push_back(1'b1); exp_addr.push_back(AW'(j)); exp_data.push_back(stim[imc + j]);
        end
    endtask

    // Compare process: every observed write against the scoreboard
    always @(negedge clk) begin : monitor
        logic im_w, dm_w, m;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        im_w = (im_cen_load == 1'b0);
        dm_w = (dm_cen_load == 1'b0);
        if (im_w && dm_w)
            check("strobe_overlap", 64'({im_cen_load, dm_cen_load}), 64'(2'b11));
        if (im_w || dm_w) begin
            nwr++;
            if (im_w) begin
                im_shadow[im_addr_load] = im_datain_load;
                last_im_addr = im_addr_load;
            end else begin
                dm_shadow[dm_addr_load] = dm_datain_load;
            end
            if (exp_addr.size() == 0) begin
                check("unexpected_write", 64'(exp_addr.size()), 64'(1));
            end else begin
                m = exp_dm.pop_front(); a = exp_addr.pop_front(); d = exp_data.pop_front();
                check("wr_port", 64'(dm_w), 64'(m));
                check("wr_addr", 64'(im_w ? im_addr_load : dm_addr_load), 64'(a));
                check("wr_data", 64'(im_w ? im_datain_load : dm_datain_load), 64'(d));
                check("wr_wen_oen", 64'(im_w ? {im_wen_load, im_oen_load} : {dm_wen_load, dm_oen_load}),
                      64'(2'b01));
            end
        end
        if (in_valid && in_ready) begin
            acc_cnt++;
            last_acc = cyc;
        end
        if (in_ready) ready_seen = 1'b1;
        if (last_acc >= 0 && cyc == last_acc + 1) rdy_after = in_ready;
        if (loading_prev && !loading && fall_cyc < 0) fall_cyc = cyc;
        if (!core_prev && core_rst_n && rise_cyc < 0) rise_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        loading_prev = loading;
        core_prev = core_rst_n;
    end

    task automatic check_reset_vals();
        check("rst_loading", 64'(loading), 64'h0);
        check("rst_core_rst_n", 64'(core_rst_n), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'h0);
        check("rst_strobes", 64'({im_cen_load, im_wen_load, im_oen_load,
                                  dm_cen_load, dm_wen_load, dm_oen_load}), 64'h3F);
        check("rst_addr_data", 64'({im_addr_load, dm_addr_load}) | 64'(im_datain_load)
                               | 64'(dm_datain_load), 64'h0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_checksum", 64'(checksum), 64'h0);
`endif
    endtask

    // Assert rst from the current cycle; check reset values one edge later
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic begin_session(input int im, input int dm, output int s);
        im_words = CW'(im); dm_words = CW'(dm); start = 1'b1;
        @(negedge clk); s = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Present stim words with the in_valid pattern (1 once the pattern ends)
    task automatic feed(input int max_cycles);
        int k = 0;
        for (int c = 0; c < max_cycles && k < stim.size(); c++) begin
            in_valid = (c < vpat.size()) ? vpat[c] : 1'b1;
            in_data  = stim[k];
            @(negedge clk);
            if (in_valid && in_ready) k++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic finish_session(input int n_wr, input int s_cyc);
        int w = 0;
        while (done_cnt == 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        check("done_count", 64'(done_cnt), 64'(1));
        check("write_count", 64'(nwr), 64'(n_wr));
        check("sb_empty", 64'(exp_addr.size()), 64'(0));
        if (acc_cnt > 0) begin
            check("loading_fall", 64'(fall_cyc), 64'(last_acc + 2));
            check("core_release", 64'(rise_cyc), 64'(last_acc + 3));
            check("ready_after_last", 64'(rdy_after), 64'(0));
        end else begin
            check("loading_fall", 64'(fall_cyc), 64'(s_cyc + 2));
            check("core_release", 64'(rise_cyc), 64'(s_cyc + 3));
        end
        check("done_at_release", 64'(done_cyc), 64'(rise_cyc));
        check("run_outputs", 64'({busy, loading, core_rst_n, in_ready}), 64'(4'b0010));
    endtask

    initial begin : main
        int s;
        clear_trk();
        do_reset();

        // 1: IM 3 words, DM 2 words, in_valid held high
        clear_trk();
        stim = '{32'h11, 32'h22, 32'h33, 32'hA0, 32'hB0}; vpat = {};
        push_expect(3, 2);
        begin_session(3, 2, s);
        check("busy_after_start", 64'({busy, loading, core_rst_n}), 64'(3'b110));
        feed(20);
        finish_session(5, s);
        check("t1_im2", 64'(im_shadow[2]), 64'h33);
        check("t1_dm0", 64'(dm_shadow[0]), 64'hA0);
        check("t1_dm1", 64'(dm_shadow[1]), 64'hB0);
        check("t1_accepts", 64'(acc_cnt), 64'(5));
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        repeat (2) @(negedge clk);
        check("start_in_run_ignored", 64'({busy, loading, core_rst_n}), 64'(3'b001));
        check("done_once_in_run", 64'(done_cnt), 64'(1));

        // 2: zero words, stream offered but never taken
        do_reset(); clear_trk();
        stim = {}; vpat = {};
        in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        begin_session(0, 0, s);
        finish_session(0, s);
        in_valid = 1'b0;
        check("zero_ready_seen", 64'(ready_seen), 64'(0));
        check("zero_done_cycle", 64'(done_cyc), 64'(s + 3));

        // 3: im_words=4 with gapped in_valid; 5th word must not be consumed
        do_reset(); clear_trk();
        stim = '{32'h1000, 32'h2000, 32'h3000, 32'h4000, 32'h5000};
        vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        push_expect(4, 0);
        begin_session(4, 0, s);
        feed(12);
        finish_session(4, s);
        check("t3_accepts", 64'(acc_cnt), 64'(4));
        check("t3_last_addr", 64'(last_im_addr), 64'(3));
        check("t3_last_accept_cycle", 64'(last_acc), 64'(s + 7));

        // 4: im_words=4095 clamps to 2048; extra words are not consumed
        do_reset(); clear_trk();
        stim = {}; vpat = {};
        for (int i = 0; i < 2050; i++) stim.push_back(32'h9E37_0000 ^ DW'(i * 7));
        push_expect(4095, 0);
        begin_session(4095, 0, s);
        feed(2060);
        finish_session(2048, s);
        check("clamp_accepts", 64'(acc_cnt), 64'(2048));
        check("clamp_last_addr", 64'(last_im_addr), 64'h7FF);
        check("clamp_last_data", 64'(im_shadow[2047]), 64'(32'h9E37_0000 ^ 32'd14329));

        // 5: rst after 2 of 5 words, during the second write
        do_reset(); clear_trk();
        stim = '{32'h101, 32'h102}; vpat = {};
        push_expect(5, 0);
        begin_session(5, 0, s);
        feed(10);
        do_reset();
        check("rst_mid_accepts", 64'(acc_cnt), 64'(2));
        check("rst_mid_sb_empty", 64'(exp_addr.size()), 64'(0));
        check("rst_mid_no_done", 64'(done_cnt), 64'(0));
        clear_trk();
        stim = '{32'h5, 32'h6}; vpat = {};
        push_expect(2, 0);
        begin_session(2, 0, s);
        feed(10);
        finish_session(2, s);
        check("restart_addr0", 64'(im_shadow[0]), 64'h5);

`ifdef LOADER_CHECKSUM_EN
        // 6: checksum wraps modulo 2^32 and restarts each session
        do_reset(); clear_trk();
        stim = '{32'hFFFF_FFFF, 32'h0000_0002}; vpat = {};
        push_expect(1, 1);
        begin_session(1, 1, s);
        feed(10);
        finish_session(2, s);
        check("checksum_wrap", 64'(checksum), 64'h1);
        do_reset(); clear_trk();
        stim = '{32'h10, 32'h20}; vpat = {};
        push_expect(2, 0);
        begin_session(2, 0, s);
        feed(10);
        finish_session(2, s);
        check("checksum_second", 64'(checksum), 64'h30);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached (tests %0d, failed %0d)", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
